pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB) around the execute stage.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and helpers for the pipeline hazard controller
//   fwd_sel_e      : operand source for the EX instruction (regfile, EX/MEM, MEM/WB)
//   hazard_state_e : controller state (run, waiting on data memory, halted on timeout)
//   stage_tag_t    : per-stage destination tracking {valid, rd, wen, is_load}
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALT
    } hazard_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
    } stage_tag_t;

    localparam stage_tag_t TAG_NONE = '0;

    function automatic logic tag_hit(input stage_tag_t t, input logic [4:0] rs);
        return t.valid && t.wen && t.rd == rs;
    endfunction

    // Nearest producer wins; a source the instruction does not read keeps the regfile path.
    function automatic fwd_sel_e fwd_pick(input logic used, input logic [4:0] rs,
                                          input stage_tag_t ex, input stage_tag_t mem);
        return !used ? FWD_RF : tag_hit(ex, rs) ? FWD_EXMEM : tag_hit(mem, rs) ? FWD_MEMWB : FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// pipeline_hazard_ctrl_scoreboard: EX/MEM/WB destination-tag shift register
//   clk_i, rst_i  : clock, synchronous active-high reset (all tags invalid)
//   hold_i        : freeze every tag (memory wait / halt)
//   bubble_i      : load an invalid tag into EX instead of the ID tag
//   id_tag_i      : tag of the instruction leaving ID
//   ex_tag_o, mem_tag_o, wb_tag_o : tags of the instructions in EX, MEM, WB
module pipeline_hazard_ctrl_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic       bubble_i,
    input  stage_tag_t id_tag_i,
    output stage_tag_t ex_tag_o,
    output stage_tag_t mem_tag_o,
    output stage_tag_t wb_tag_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_tag_o  <= TAG_NONE;
            mem_tag_o <= TAG_NONE;
            wb_tag_o  <= TAG_NONE;
        end else if (!hold_i) begin
            ex_tag_o  <= bubble_i ? TAG_NONE : id_tag_i;
            mem_tag_o <= ex_tag_o;
            wb_tag_o  <= mem_tag_o;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for a 5-stage RV32I pipeline
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   id_*                         : decoded fields of the instruction in ID
//   ex_next_pc_ena_i             : EX redirects the PC
//   mem_busy_i                   : data memory cannot complete this cycle
//   if/id/ex/mem_stall_o         : per-stage hold enables
//   id_flush_o, ex_flush_o       : bubble IF/ID, ID/EX
//   fwd_rs1_sel_o, fwd_rs2_sel_o : registered operand selects for EX (fwd_sel_e encoding)
//   mem_timeout_o                : sticky, memory wait reached MEM_TIMEOUT cycles
//   stall_cnt_o, flush_cnt_o     : saturating stall-cycle and redirect counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_wrt_ena_i,
    input  logic             id_is_load_i,
    input  logic             ex_next_pc_ena_i,
    input  logic             mem_busy_i,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             ex_stall_o,
    output logic             mem_stall_o,
    output logic             id_flush_o,
    output logic             ex_flush_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int BW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [BW-1:0] BUSY_TOP = BW'(MEM_TIMEOUT - 1);

    hazard_state_e state, state_nxt;
    logic [BW-1:0] busy_cnt;
    stage_tag_t    id_tag, ex_tag, mem_tag, wb_tag;
    fwd_sel_e      fwd1, fwd2;
    logic          frozen, redirect, load_use, bubble;
    logic          unused_tags;

    // x0 is never a real destination, so it can neither forward nor cause a load-use stall.
    assign id_tag = '{valid:   id_valid_i,
                      rd:      id_rd_addr_i,
                      wen:     id_valid_i && id_rd_wrt_ena_i && id_rd_addr_i != 5'd0,
                      is_load: id_is_load_i};

    // WB tags only retire; the regfile write-back covers them.
    assign unused_tags = ^{wb_tag, mem_tag.is_load};

    // A MEM_WAIT cycle with mem_busy_i low is the release cycle and already behaves as RUN,
    // so a redirect held in the frozen EX stage is taken on that first non-busy cycle.
    always_comb begin
        frozen   = state == ST_HALT || mem_busy_i;
        redirect = !rst_i && !frozen && ex_next_pc_ena_i;
        load_use = !rst_i && !frozen && !ex_next_pc_ena_i && id_valid_i &&
                   ex_tag.valid && ex_tag.is_load && ex_tag.wen &&
                   ((id_rs1_used_i && id_rs1_addr_i == ex_tag.rd) ||
                    (id_rs2_used_i && id_rs2_addr_i == ex_tag.rd));
        bubble   = redirect || load_use;
    end

    always_ff @(posedge clk_i) begin
        state <= rst_i ? ST_RUN : state_nxt;
    end

    always_comb begin
        state_nxt = state == ST_HALT ? ST_HALT :
                    !mem_busy_i      ? ST_RUN  :
                    busy_cnt == BUSY_TOP ? ST_HALT : ST_MEM_WAIT;
    end

    always_comb begin
        if_stall_o    = !rst_i && (frozen || load_use);
        id_stall_o    = !rst_i && (frozen || load_use);
        ex_stall_o    = !rst_i && frozen;
        mem_stall_o   = !rst_i && frozen;
        id_flush_o    = rst_i || redirect;
        ex_flush_o    = rst_i || bubble;
        mem_timeout_o = state == ST_HALT;
        fwd_rs1_sel_o = fwd1;
        fwd_rs2_sel_o = fwd2;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cnt    <= '0;
            fwd1        <= FWD_RF;
            fwd2        <= FWD_RF;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            busy_cnt    <= !mem_busy_i ? '0 : busy_cnt == BUSY_TOP ? busy_cnt : busy_cnt + 1'b1;
            stall_cnt_o <= stall_cnt_o + CNT_W'(if_stall_o && !(&stall_cnt_o));
            flush_cnt_o <= flush_cnt_o + CNT_W'(redirect && !(&flush_cnt_o));
            if (!frozen) begin
                fwd1 <= bubble ? FWD_RF : fwd_pick(id_rs1_used_i, id_rs1_addr_i, ex_tag, mem_tag);
                fwd2 <= bubble ? FWD_RF : fwd_pick(id_rs2_used_i, id_rs2_addr_i, ex_tag, mem_tag);
            end
        end
    end

    pipeline_hazard_ctrl_scoreboard u_sb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .hold_i    (frozen),
        .bubble_i  (bubble),
        .id_tag_i  (id_tag),
        .ex_tag_o  (ex_tag),
        .mem_tag_o (mem_tag),
        .wb_tag_o  (wb_tag)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_wrt_ena_i, id_is_load_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic       ex_next_pc_ena_i, mem_busy_i;
    logic       if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o;
    logic [1:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
    logic       mem_timeout_o;
    logic [2:0] stall_cnt_o, flush_cnt_o;
    int         n_assert = 0;
    int         n_fail = 0;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .id_valid_i       (id_valid_i),
        .id_rs1_addr_i    (id_rs1_addr_i),
        .id_rs2_addr_i    (id_rs2_addr_i),
        .id_rs1_used_i    (id_rs1_used_i),
        .id_rs2_used_i    (id_rs2_used_i),
        .id_rd_addr_i     (id_rd_addr_i),
        .id_rd_wrt_ena_i  (id_rd_wrt_ena_i),
        .id_is_load_i     (id_is_load_i),
        .ex_next_pc_ena_i (ex_next_pc_ena_i),
        .mem_busy_i       (mem_busy_i),
        .if_stall_o       (if_stall_o),
        .id_stall_o       (id_stall_o),
        .ex_stall_o       (ex_stall_o),
        .mem_stall_o      (mem_stall_o),
        .id_flush_o       (id_flush_o),
        .ex_flush_o       (ex_flush_o),
        .fwd_rs1_sel_o    (fwd_rs1_sel_o),
        .fwd_rs2_sel_o    (fwd_rs2_sel_o),
        .mem_timeout_o    (mem_timeout_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control vector {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_flush_o},
            {26'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic w, input logic ld);
        id_valid_i      = v;
        id_rs1_addr_i   = rs1;
        id_rs2_addr_i   = rs2;
        id_rs1_used_i   = u1;
        id_rs2_used_i   = u2;
        id_rd_addr_i    = rd;
        id_rd_wrt_ena_i = w;
        id_is_load_i    = ld;
    endtask

    task automatic idle;
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1;
        ex_next_pc_ena_i = 1'b0;
        mem_busy_i = 1'b0;
        idle();
        settle();
        chk_ctl("rst_ctl", 6'b000011);
        tick();
        tick();
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
        chk("rst_fwd1", fwd_rs1_sel_o, 0);
        chk("rst_timeout", mem_timeout_o, 0);
        rst_i = 1'b0;

        // addi x5 ; add x6,x5,x5 ; sub x9,x5,x6
        id_set(1, 0, 0, 1, 0, 5, 1, 0);
        settle();
        chk_ctl("t1_addi_ctl", 6'b000000);
        tick();
        id_set(1, 5, 5, 1, 1, 6, 1, 0);
        settle();
        chk_ctl("t1_add_ctl", 6'b000000);
        tick();
        chk("t1_add_fwd1", fwd_rs1_sel_o, 1);
        chk("t1_add_fwd2", fwd_rs2_sel_o, 1);
        id_set(1, 5, 6, 1, 1, 9, 1, 0);
        tick();
        chk("t1_sub_fwd1", fwd_rs1_sel_o, 2);
        chk("t1_sub_fwd2", fwd_rs2_sel_o, 1);
        idle();
        tick();
        tick();

        // lw x7 ; add x8,x7,x0
        id_set(1, 0, 0, 1, 0, 7, 1, 1);
        settle();
        chk_ctl("t2_lw_ctl", 6'b000000);
        tick();
        id_set(1, 7, 0, 1, 1, 8, 1, 0);
        settle();
        chk_ctl("t2_loaduse_ctl", 6'b110001);
        tick();
        chk("t2_stall_cnt", stall_cnt_o, 1);
        chk_ctl("t2_second_ctl", 6'b000000);
        tick();
        chk("t2_fwd1", fwd_rs1_sel_o, 2);
        chk("t2_fwd2", fwd_rs2_sel_o, 0);
        chk("t2_stall_cnt_after", stall_cnt_o, 1);
        idle();
        tick();
        tick();

        // redirect and load-use together: redirect wins
        id_set(1, 0, 0, 1, 0, 7, 1, 1);
        tick();
        id_set(1, 7, 0, 1, 1, 8, 1, 0);
        ex_next_pc_ena_i = 1'b1;
        settle();
        chk_ctl("t3_redirect_ctl", 6'b000011);
        tick();
        chk("t3_flush_cnt", flush_cnt_o, 1);
        chk("t3_stall_cnt", stall_cnt_o, 1);
        chk("t3_fwd1", fwd_rs1_sel_o, 0);
        ex_next_pc_ena_i = 1'b0;
        idle();
        tick();
        tick();

        // redirect held in EX across 3 busy cycles
        id_set(1, 0, 0, 1, 1, 10, 1, 0);
        ex_next_pc_ena_i = 1'b1;
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_ctl($sformatf("t4_busy%0d_ctl", i), 6'b111100);
            tick();
        end
        mem_busy_i = 1'b0;
        settle();
        chk_ctl("t4_release_ctl", 6'b000011);
        tick();
        chk("t4_flush_cnt", flush_cnt_o, 2);
        chk("t4_stall_cnt", stall_cnt_o, 4);
        chk("t4_timeout", mem_timeout_o, 0);
        ex_next_pc_ena_i = 1'b0;
        idle();
        tick();

        // writes to x0 never forward or stall
        id_set(1, 0, 0, 1, 0, 5, 1, 0);
        tick();
        id_set(1, 5, 0, 1, 0, 0, 1, 0);
        tick();
        chk("t6_rd0_fwd1", fwd_rs1_sel_o, 1);
        id_set(1, 0, 0, 1, 1, 11, 1, 0);
        settle();
        chk_ctl("t6_read_x0_ctl", 6'b000000);
        tick();
        chk("t6_x0_fwd1", fwd_rs1_sel_o, 0);
        chk("t6_x0_fwd2", fwd_rs2_sel_o, 0);
        id_set(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        id_set(1, 0, 0, 1, 1, 12, 1, 0);
        settle();
        chk_ctl("t6_lw_x0_ctl", 6'b000000);
        tick();
        idle();
        tick();
        tick();

        // memory timeout after 4 busy cycles, sticky until reset
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_ctl($sformatf("t5_busy%0d_ctl", i), 6'b111100);
            tick();
        end
        chk("t5_stall_cnt_sat", stall_cnt_o, 7);
        chk("t5_timeout_early", mem_timeout_o, 0);
        tick();
        chk("t5_timeout_set", mem_timeout_o, 1);
        mem_busy_i = 1'b0;
        ex_next_pc_ena_i = 1'b1;
        settle();
        chk_ctl("t5_halt_ctl", 6'b111100);
        tick();
        tick();
        chk("t5_timeout_sticky", mem_timeout_o, 1);
        chk("t5_stall_cnt_hold", stall_cnt_o, 7);
        chk("t5_flush_cnt_hold", flush_cnt_o, 2);
        rst_i = 1'b1;
        settle();
        chk_ctl("t5_rst_ctl", 6'b000011);
        tick();
        chk("t5_rst_timeout", mem_timeout_o, 0);
        chk("t5_rst_stall_cnt", stall_cnt_o, 0);
        chk("t5_rst_flush_cnt", flush_cnt_o, 0);
        rst_i = 1'b0;
        ex_next_pc_ena_i = 1'b0;
        settle();
        chk_ctl("t5_run_ctl", 6'b000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
